// File: rtl/mc_control_unit_pkg.sv
// Shared encodings for the multi-cycle control unit and the datapath muxes
// it steers: opcode values, FSM state codes, memtoreg/regdest select codes,
// trap causes, and a classifier that maps an opcode to its instruction class.
package mc_control_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd7
    } state_e;

    // Opcode values (6-bit primary opcode field)
    localparam logic [5:0] OP_RFMT = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BLE  = 6'b000110;
    localparam logic [5:0] OP_BGT  = 6'b000111;
    localparam logic [5:0] OP_BLT  = 6'b010100;
    localparam logic [5:0] OP_BGE  = 6'b010101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    // memtoreg select
    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC4 = 2'b10;

    // regdest select
    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    // trap causes
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        CL_ILLEGAL = 3'd0,
        CL_RTYPE   = 3'd1,
        CL_ALUI    = 3'd2,
        CL_LOAD    = 3'd3,
        CL_STORE   = 3'd4,
        CL_BRANCH  = 3'd5,
        CL_JUMP    = 3'd6,
        CL_JAL     = 3'd7
    } op_class_e;

    function automatic op_class_e op_class(input logic [5:0] op);
        op_class_e c;
        case (op)
            OP_RFMT:                                         c = CL_RTYPE;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI:               c = CL_ALUI;
            OP_LW:                                           c = CL_LOAD;
            OP_SW:                                           c = CL_STORE;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGT, OP_BGE, OP_BLE:  c = CL_BRANCH;
            OP_J:                                            c = CL_JUMP;
            OP_JAL:                                          c = CL_JAL;
            default:                                         c = CL_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-state timer.
// Ports: clk/rst (async active-high), clr (synchronous clear, wins over inc),
// inc (one more wait cycle), timeout (high on the wait cycle that brings the
// count to MEM_TIMEOUT).
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] count_r;

    // Wait-cycle counter: clear has priority, otherwise count up while waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (inc) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Combinational so the FSM can leave on the exact cycle the limit is hit
    assign timeout = inc & (count_r == LAST_WAIT);

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control unit: Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB.
// Ports: clk, rst (async active-high); ir (opcode field, sampled in DECODE);
// mem_ready (memory handshake); branch_taken (ALU compare, valid in EXEC);
// datapath controls alusrc, memread, memwrite, regwrite, memtoreg, regdest,
// branch, Jump, pc_write, ir_write; debug state; trap and trap_cause.
module mc_control_unit
    import mc_control_unit_pkg::*;
#(
    parameter int OPW         = 6,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] ir,
    input  logic           mem_ready,
    input  logic           branch_taken,
    output logic           alusrc,
    output logic           memread,
    output logic           memwrite,
    output logic           regwrite,
    output logic [1:0]     memtoreg,
    output logic [1:0]     regdest,
    output logic           branch,
    output logic           Jump,
    output logic           pc_write,
    output logic           ir_write,
    output logic [2:0]     state,
    output logic           trap,
    output logic [1:0]     trap_cause
);

    state_e         state_r, next_s;
    logic [OPW-1:0] op_r, op_s;
    logic [5:0]     op6_s;
    op_class_e      cls_s;
    logic [1:0]     cause_s, trap_cause_r;
    logic           timeout_s, tmr_clr_s, tmr_inc_s;

    logic       alusrc_s, memread_s, memwrite_s, regwrite_s, branch_s, jump_s, fetch_s, trap_s;
    logic [1:0] memtoreg_s, regdest_s;
    logic       alusrc_r, memread_r, memwrite_r, regwrite_r, branch_r, jump_r, fetch_r, trap_r;
    logic [1:0] memtoreg_r, regdest_r;

    // Opcode in effect: live ir while decoding, the latched copy afterwards
    always_comb begin
        if (state_r == ST_DECODE) begin
            op_s = ir;
        end else begin
            op_s = op_r;
        end
    end

    // Any bits above the 6-bit opcode space must be zero to be legal
    assign op6_s = 6'(op_s);
    assign cls_s = (op_s == OPW'(op6_s)) ? op_class(op6_s) : CL_ILLEGAL;

    assign tmr_inc_s = ((state_r == ST_FETCH) || (state_r == ST_MEM)) && !mem_ready;
    assign tmr_clr_s = (next_s != state_r) || mem_ready;

    mc_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr_s),
        .inc     (tmr_inc_s),
        .timeout (timeout_s)
    );

    // State, latched opcode and trap cause registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            op_r         <= '0;
            trap_cause_r <= CAUSE_NONE;
        end else begin
            state_r      <= next_s;
            op_r         <= op_s;
            trap_cause_r <= cause_s;
        end
    end

    // Next-state logic, then output decode from the upcoming state
    always_comb begin
        next_s     = state_r;
        cause_s    = trap_cause_r;
        alusrc_s   = 1'b0;
        memread_s  = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        memtoreg_s = M2R_ALU;
        regdest_s  = RD_RT;
        branch_s   = 1'b0;
        jump_s     = 1'b0;
        fetch_s    = 1'b0;
        trap_s     = 1'b0;

        case (state_r)
            ST_IDLE:   next_s = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready) begin
                    next_s = ST_DECODE;
                end else if (timeout_s) begin
                    next_s  = ST_TRAP;
                    cause_s = CAUSE_TIMEOUT;
                end else begin
                    next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (cls_s == CL_ILLEGAL) begin
                    next_s  = ST_TRAP;
                    cause_s = CAUSE_ILLEGAL;
                end else begin
                    next_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cls_s)
                    CL_RTYPE, CL_ALUI: next_s = ST_WB;
                    CL_LOAD, CL_STORE: next_s = ST_MEM;
                    default:           next_s = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    next_s = (cls_s == CL_LOAD) ? ST_WB : ST_FETCH;
                end else if (timeout_s) begin
                    next_s  = ST_TRAP;
                    cause_s = CAUSE_TIMEOUT;
                end else begin
                    next_s = ST_MEM;
                end
            end
            ST_WB:     next_s = ST_FETCH;
            ST_TRAP:   next_s = ST_TRAP;
            default:   next_s = ST_IDLE;
        endcase

        case (next_s)
            ST_FETCH: begin
                memread_s = 1'b1;
                fetch_s   = 1'b1;
            end
            ST_EXEC: begin
                case (cls_s)
                    CL_ALUI, CL_LOAD, CL_STORE: alusrc_s = 1'b1;
                    CL_BRANCH:                  branch_s = 1'b1;
                    CL_JUMP:                    jump_s   = 1'b1;
                    CL_JAL: begin
                        jump_s     = 1'b1;
                        regwrite_s = 1'b1;
                        regdest_s  = RD_RA;
                        memtoreg_s = M2R_PC4;
                    end
                    default:                    alusrc_s = 1'b0;
                endcase
            end
            ST_MEM: begin
                if (cls_s == CL_LOAD) begin
                    memread_s = 1'b1;
                end else begin
                    memwrite_s = 1'b1;
                end
            end
            ST_WB: begin
                regwrite_s = 1'b1;
                if (cls_s == CL_RTYPE) begin
                    regdest_s = RD_RD;
                end else if (cls_s == CL_LOAD) begin
                    memtoreg_s = M2R_MEM;
                end else begin
                    regdest_s = RD_RT;
                end
            end
            ST_TRAP:  trap_s = 1'b1;
            default:  trap_s = 1'b0;
        endcase
    end

    // Registered control outputs for the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alusrc_r   <= 1'b0;
            memread_r  <= 1'b0;
            memwrite_r <= 1'b0;
            regwrite_r <= 1'b0;
            memtoreg_r <= M2R_ALU;
            regdest_r  <= RD_RT;
            branch_r   <= 1'b0;
            jump_r     <= 1'b0;
            fetch_r    <= 1'b0;
            trap_r     <= 1'b0;
        end else begin
            alusrc_r   <= alusrc_s;
            memread_r  <= memread_s;
            memwrite_r <= memwrite_s;
            regwrite_r <= regwrite_s;
            memtoreg_r <= memtoreg_s;
            regdest_r  <= regdest_s;
            branch_r   <= branch_s;
            jump_r     <= jump_s;
            fetch_r    <= fetch_s;
            trap_r     <= trap_s;
        end
    end

    assign alusrc     = alusrc_r;
    assign memread    = memread_r;
    assign memwrite   = memwrite_r;
    assign regwrite   = regwrite_r;
    assign memtoreg   = memtoreg_r;
    assign regdest    = regdest_r;
    assign branch     = branch_r;
    assign Jump       = jump_r;
    assign trap       = trap_r;
    assign trap_cause = trap_cause_r;
    assign state      = state_r;

    // Strobes qualified by same-cycle handshakes: the fetch completes only when
    // memory is ready, and a branch updates PC only when the compare is taken.
    assign ir_write = fetch_r & mem_ready;
    assign pc_write = jump_r | (fetch_r & mem_ready) | (branch_r & branch_taken);

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
Multi-cycle successor to the single-cycle opcode decoder. A Moore FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the same datapath control set (alusrc, memread, memwrite, regwrite, memtoreg, regdest, branch, Jump), plus pc_write/ir_write. It adds:
- memory wait-state handshake with timeout;
- illegal-opcode trap;
- a parametrised opcode width.

It sits between the instruction register and the datapath/memory interface of the multi-cycle core.

Parameters:
OPW, 6, opcode field width
MEM_TIMEOUT, 15, max consecutive mem_ready-low cycles before bus-error trap (1..255)
CNT_W, 8, width of wait counter; must satisfy 2**CNT_W > MEM_TIMEOUT

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
ir  in  OPW  opcode field; sampled in DECODE only
mem_ready  in  1  memory completes current read/write this cycle
branch_taken  in  1  ALU compare result; valid in EXEC of branch ops
alusrc  out  1  0 = rt register, 1 = immediate
memread  out  1  memory read request
memwrite  out  1  memory write request
regwrite  out  1  register-file write enable
memtoreg  out  2  00 = ALU, 01 = memory, 10 = PC+4
regdest  out  2  00 = rt, 01 = rd, 10 = $31
branch  out  1  conditional branch in progress
Jump  out  1  unconditional jump target select
pc_write  out  1  PC update strobe
ir_write  out  1  IR load strobe
state  out  3  current state encoding (debug/verification)
trap  out  1  FSM halted in TRAP
trap_cause  out  2  01 = illegal opcode, 10 = memory timeout

Behaviour:
- Reset (async, rst high): state = IDLE (0); every output 0, including memtoreg, regdest and trap_cause; wait counter 0; latched opcode 0.
- Outputs are registered and decoded from next_state, so they are valid in the same cycle the state register holds that state.
- State encoding: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, TRAP 7.
- IDLE: always moves to FETCH on the next edge after rst deasserts.
- FETCH: memread = 1.
  - If mem_ready: ir_write = 1, pc_write = 1 (PC+4) -> DECODE.
  - Else stay and increment the wait counter.
  - Counter reaching MEM_TIMEOUT -> TRAP, cause 10.
- DECODE: latch ir into the opcode register.
  - Supported opcodes are rfmt, j, jal, beq, bne, blt, bgt, bge, ble, addi, andi, ori, xori, lw, sw; these -> EXEC.
  - Any other opcode -> TRAP, cause 01.
- EXEC:
  - rfmt: alusrc = 0 -> WB.
  - addi/andi/ori/xori: alusrc = 1 -> WB.
  - lw/sw: alusrc = 1 -> MEM.
  - Branches: branch = 1, pc_write = branch_taken, regwrite = 0 -> FETCH.
  - j: Jump = 1, pc_write = 1 -> FETCH.
  - jal: Jump = 1, pc_write = 1, regwrite = 1, regdest = 10, memtoreg = 10 -> FETCH.
- MEM:
  - lw: memread = 1 until mem_ready -> WB.
  - sw: memwrite = 1 until mem_ready -> FETCH.
  - Same timeout rule as FETCH applies.
- WB: regwrite = 1.
  - rfmt: regdest = 01, memtoreg = 00.
  - I-type ALU ops: regdest = 00, memtoreg = 00.
  - lw: regdest = 00, memtoreg = 01.
  - Next state: FETCH.
- Wait counter: cleared on every state change and whenever mem_ready = 1.
- memread and memwrite are never high in the same cycle.
- Immediate ALU ops never assert memread.
- Nominal latency with mem_ready always high:
  - R-type and I-type ALU: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Branches, j, jal: 3 cycles.
  - Each low cycle of mem_ready adds 1 cycle.
- TRAP: all strobes 0; trap = 1; trap_cause holds. Only rst exits TRAP.
- Reset asserted mid-instruction (any state): immediate return to IDLE with all outputs 0; no partial pc_write or regwrite after the reset edge.
- Unknown or X opcode outside DECODE is ignored; only the latched opcode drives decode.

Decomposition:
- Shared package holds:
  - opcode localparams;
  - state encodings;
  - memtoreg and regdest encodings;
  - trap_cause codes.
- The same package is reused by the datapath muxes.
- One natural sub-module: mc_wait_timer (counter, clear, increment, timeout flag at MEM_TIMEOUT).
- Next-state and output decode stay inline in mc_control_unit.

Test Plan:
- Reset, then ir = lw (100011), mem_ready = 1. Required: states 1, 2, 3, 4, 5, 1. memread high in FETCH and MEM. WB has regwrite = 1, memtoreg = 01, regdest = 00.
- ir = sw (101011), mem_ready low for 3 cycles in MEM. Required: MEM lasts 4 cycles with memwrite = 1 throughout, then FETCH; regwrite stays 0.
- ir = beq (000100) with branch_taken = 1, then again with branch_taken = 0. Required: EXEC branch = 1 in both; pc_write = 1 and 0 respectively; 3 cycles total each.
- ir = jal (000011). Required: EXEC has Jump = 1, pc_write = 1, regwrite = 1, regdest = 10, memtoreg = 10.
- ir = 111111 (illegal). Required: TRAP after DECODE, trap = 1, cause 01, held for 20 cycles. Then pulse rst: IDLE, then FETCH.
- mem_ready held low in FETCH with MEM_TIMEOUT = 15. Required: TRAP with cause 10 after 15 wait cycles. Separately, rst asserted mid-MEM of lw: outputs 0 immediately, and no regwrite pulse follows.
